spi_frame_decoder: RTL and testbench

SCK-domain command/address front end for the slave SPI PHY. It deserialises MOSI on `trigger_clock`, decodes an 8-bit opcode and a 16-bit address, and publishes write bytes, read requests and the read start bit-moment. The read start bit-moment drives `send_momment` of the 8-bit TX PHY. Every output is a level or a toggle, held stable between SCK edges, so that system-clock logic can resynchronise it.

---
 rtl/spi_frame_decoder_pkg.sv | 24 ++
 rtl/spi_bit_shifter.sv | 35 +++
 rtl/spi_frame_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_spi_frame_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_decoder_pkg.sv
// -----------------------------------------------------------------------------
// spi_phy_defs
// Shared definitions for the slave SPI PHY front end.
//   SPI_OP_READ / SPI_OP_WRITE : opcode constants, used as parameter defaults
//   SPI_BIT_MOMENT_W           : width of bit counters / bit-moment values
//   spi_state_e                : frame decoder state encoding (3 bits)
// No ports (package).
// -----------------------------------------------------------------------------
package spi_phy_defs;

   localparam logic [7:0] SPI_OP_READ      = 8'h03;
   localparam logic [7:0] SPI_OP_WRITE     = 8'h02;
   localparam int         SPI_BIT_MOMENT_W = 24;

   typedef enum logic [2:0] {
      ST_CMD    = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DUMMY  = 3'd2,
      ST_RD     = 3'd3,
      ST_WR     = 3'd4,
      ST_IGNORE = 3'd5
   } spi_state_e;

endpackage

// File: rtl/spi_bit_shifter.sv
// -----------------------------------------------------------------------------
// spi_bit_shifter
// N-bit MSB-first serial-in shift register with asynchronous clear.
// Only the N-1 most recent bits are stored; word_o presents them together with
// the bit currently on din_i, so word_o is the complete N-bit word exactly on
// the edge that samples its last bit (no extra cycle of latency).
// Ports:
//   trigger_clock  in  sampling clock (rising edge)
//   trigger_rst_n  in  asynchronous clear, active-low
//   din_i          in  serial data, MSB first
//   word_o         out {last N-1 sampled bits, din_i}
// Requires N >= 2.
// -----------------------------------------------------------------------------
module spi_bit_shifter #(
   parameter int N = 8
) (
   input  logic         trigger_clock,
   input  logic         trigger_rst_n,
   input  logic         din_i,
   output logic [N-1:0] word_o
);

   logic [N-2:0] hist_q;

   assign word_o = {hist_q, din_i};

   always_ff @(posedge trigger_clock or negedge trigger_rst_n) begin
      if (!trigger_rst_n) begin
         hist_q <= '0;
      end else begin
         hist_q <= word_o[N-2:0];
      end
   end

endmodule

// File: rtl/spi_frame_decoder.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder
// SCK-domain command/address front end for the slave SPI PHY. Deserialises MOSI,
// decodes an 8-bit opcode and an ADDR_BITS address, then publishes write bytes,
// read requests and the bit index at which MISO data starts. All outputs are
// registered levels/toggles that only change on trigger_clock rising edges or
// reset, so system-clock logic can resynchronise them.
// Build option: define SPI_FRAME_ADDR_INC_EN to post-increment addr once per
// data byte (burst access); otherwise addr holds the captured address.
// Ports:
//   trigger_clock  in   sampling clock (edge opposite to TX drive edge)
//   trigger_rst_n  in   async active-low reset (~cs_n): every frame starts clean
//   mosi           in   serial data, MSB first
//   cmd            out  captured opcode
//   cmd_valid      out  cmd is valid
//   cmd_err        out  opcode is neither read nor write
//   addr           out  current data address
//   rd_req         out  read frame finished its address phase
//   rd_momment     out  bit index where MISO data starts
//   rd_toggle      out  flips at each read byte boundary
//   wr_data        out  last complete write byte
//   wr_toggle      out  flips once per complete write byte
//   bit_cnt        out  bits received this frame, saturating
// -----------------------------------------------------------------------------
module spi_frame_decoder
   import spi_phy_defs::*;
#(
   parameter int         ADDR_BITS  = 16,
   parameter int         DUMMY_BITS = 8,
   parameter logic [7:0] RD_OPCODE  = SPI_OP_READ,
   parameter logic [7:0] WR_OPCODE  = SPI_OP_WRITE
) (
   input  logic                        trigger_clock,
   input  logic                        trigger_rst_n,
   input  logic                        mosi,
   output logic [7:0]                  cmd,
   output logic                        cmd_valid,
   output logic                        cmd_err,
   output logic [ADDR_BITS-1:0]        addr,
   output logic                        rd_req,
   output logic [SPI_BIT_MOMENT_W-1:0] rd_momment,
   output logic                        rd_toggle,
   output logic [7:0]                  wr_data,
   output logic                        wr_toggle,
   output logic [SPI_BIT_MOMENT_W-1:0] bit_cnt
);

   localparam int W = SPI_BIT_MOMENT_W;

   // Compared against the bit count *before* the edge, so CMD_END matches the
   // 8th sampling edge.
   localparam logic [W-1:0] CMD_END   = W'(7);
   localparam logic [W-1:0] ADDR_END  = W'(7 + ADDR_BITS);
   localparam logic [W-1:0] DUMMY_END = W'(7 + ADDR_BITS + DUMMY_BITS);
   localparam logic [W-1:0] RD_MOMENT = W'(8 + ADDR_BITS + DUMMY_BITS);
   localparam logic [W-1:0] CNT_MAX   = '1;

`ifdef SPI_FRAME_ADDR_INC_EN
   localparam bit ADDR_INC = 1'b1;
`else
   localparam bit ADDR_INC = 1'b0;
`endif

   localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

   // ---------------------------------------------------------------- shifters
   logic [7:0]           byte_word;
   logic [ADDR_BITS-1:0] addr_word;

   spi_bit_shifter #(.N(8)) u_byte_shifter (
      .trigger_clock (trigger_clock),
      .trigger_rst_n (trigger_rst_n),
      .din_i         (mosi),
      .word_o        (byte_word)
   );

   spi_bit_shifter #(.N(ADDR_BITS)) u_addr_shifter (
      .trigger_clock (trigger_clock),
      .trigger_rst_n (trigger_rst_n),
      .din_i         (mosi),
      .word_o        (addr_word)
   );

   // ---------------------------------------------------------------- counters
   logic [W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]   bp_q,      bp_d;

   always_comb begin
      bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + W'(1);
      // The byte phase keeps running after bit_cnt saturates.
      bp_d      = bp_q + 3'd1;
   end

   always_ff @(posedge trigger_clock or negedge trigger_rst_n) begin
      if (!trigger_rst_n) begin
         bit_cnt_q <= '0;
         bp_q      <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         bp_q      <= bp_d;
      end
   end

   // ---------------------------------------------------------------- FSM
   spi_state_e           state_q;
   logic [7:0]           cmd_q;
   logic                 cmd_valid_q;
   logic                 cmd_err_q;
   logic                 is_rd_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic                 rd_req_q;
   logic [W-1:0]         rd_momment_q;
   logic                 rd_toggle_q;
   logic [7:0]           wr_data_q;
   logic                 wr_toggle_q;
   logic                 wr_seen_q;    // at least one write byte delivered

   wire byte_end = (bp_q == 3'd7);

   always_ff @(posedge trigger_clock or negedge trigger_rst_n) begin
      if (!trigger_rst_n) begin
         state_q      <= ST_CMD;
         cmd_q        <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_err_q    <= 1'b0;
         is_rd_q      <= 1'b0;
         addr_q       <= '0;
         rd_req_q     <= 1'b0;
         rd_momment_q <= '0;
         rd_toggle_q  <= 1'b0;
         wr_data_q    <= '0;
         wr_toggle_q  <= 1'b0;
         wr_seen_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_CMD: begin
               if (bit_cnt_q == CMD_END) begin
                  cmd_q       <= byte_word;
                  cmd_valid_q <= 1'b1;
                  is_rd_q     <= (byte_word == RD_OPCODE);
                  if (byte_word == RD_OPCODE || byte_word == WR_OPCODE) begin
                     state_q <= ST_ADDR;
                  end else begin
                     cmd_err_q <= 1'b1;
                     state_q   <= ST_IGNORE;
                  end
               end
            end

            ST_ADDR: begin
               if (bit_cnt_q == ADDR_END) begin
                  addr_q <= addr_word;
                  if (is_rd_q) begin
                     rd_req_q     <= 1'b1;
                     rd_momment_q <= RD_MOMENT;
                     state_q      <= (DUMMY_BITS == 0) ? ST_RD : ST_DUMMY;
                  end else begin
                     state_q <= ST_WR;
                  end
               end
            end

            ST_DUMMY: begin
               if (bit_cnt_q == DUMMY_END) begin
                  state_q <= ST_RD;
               end
            end

            ST_RD: begin
               if (byte_end) begin
                  rd_toggle_q <= ~rd_toggle_q;
                  if (ADDR_INC) begin
                     addr_q <= addr_q + ADDR_ONE;
                  end
               end
            end

            ST_WR: begin
               if (byte_end) begin
                  wr_data_q   <= byte_word;
                  wr_toggle_q <= ~wr_toggle_q;
                  wr_seen_q   <= 1'b1;
                  // Advance only from the second byte on, so addr names the
                  // byte currently presented on wr_data.
                  if (ADDR_INC && wr_seen_q) begin
                     addr_q <= addr_q + ADDR_ONE;
                  end
               end
            end

            ST_IGNORE: begin
               state_q <= ST_IGNORE;
            end

            default: begin
               state_q <= ST_IGNORE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign cmd        = cmd_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_err    = cmd_err_q;
   assign addr       = addr_q;
   assign rd_req     = rd_req_q;
   assign rd_momment = rd_momment_q;
   assign rd_toggle  = rd_toggle_q;
   assign wr_data    = wr_data_q;
   assign wr_toggle  = wr_toggle_q;
   assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_decoder
// Two decoders share clock, reset and MOSI: one with default parameters
// (DUMMY_BITS=8) and one with DUMMY_BITS=0. Each frame is described as a bit
// array; the reference model derives the expected output snapshot at any edge
// directly from the frame contents, and the stimulus pushes one snapshot per
// expected event (cmd_valid rise, rd_req rise, toggle flip). Monitors pop and
// compare whenever a DUT shows such an event. Every frame ends with reset.
// -----------------------------------------------------------------------------
module tb_spi_frame_decoder;

   localparam int AB   = 16;
   localparam int MAXB = 128;

`ifdef SPI_FRAME_ADDR_INC_EN
   localparam bit INC = 1'b1;
`else
   localparam bit INC = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  cmd;
      logic        cmd_valid;
      logic        cmd_err;
      logic [15:0] addr;
      logic        rd_req;
      logic [23:0] rd_momment;
      logic        rd_toggle;
      logic [7:0]  wr_data;
      logic        wr_toggle;
      logic [23:0] bit_cnt;
   } snap_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic mosi;

   logic [7:0]  cmd_a, cmd_b, wr_data_a, wr_data_b;
   logic        cmd_valid_a, cmd_valid_b, cmd_err_a, cmd_err_b;
   logic [15:0] addr_a, addr_b;
   logic        rd_req_a, rd_req_b, rd_toggle_a, rd_toggle_b, wr_toggle_a, wr_toggle_b;
   logic [23:0] rd_momment_a, rd_momment_b, bit_cnt_a, bit_cnt_b;

   spi_frame_decoder dut_d8 (
      .trigger_clock (clk),
      .trigger_rst_n (rst_n),
      .mosi          (mosi),
      .cmd           (cmd_a),
      .cmd_valid     (cmd_valid_a),
      .cmd_err       (cmd_err_a),
      .addr          (addr_a),
      .rd_req        (rd_req_a),
      .rd_momment    (rd_momment_a),
      .rd_toggle     (rd_toggle_a),
      .wr_data       (wr_data_a),
      .wr_toggle     (wr_toggle_a),
      .bit_cnt       (bit_cnt_a)
   );

   spi_frame_decoder #(.DUMMY_BITS(0)) dut_d0 (
      .trigger_clock (clk),
      .trigger_rst_n (rst_n),
      .mosi          (mosi),
      .cmd           (cmd_b),
      .cmd_valid     (cmd_valid_b),
      .cmd_err       (cmd_err_b),
      .addr          (addr_b),
      .rd_req        (rd_req_b),
      .rd_momment    (rd_momment_b),
      .rd_toggle     (rd_toggle_b),
      .wr_data       (wr_data_b),
      .wr_toggle     (wr_toggle_b),
      .bit_cnt       (bit_cnt_b)
   );

   snap_t act_a, act_b;
   assign act_a = {cmd_a, cmd_valid_a, cmd_err_a, addr_a, rd_req_a, rd_momment_a,
                   rd_toggle_a, wr_data_a, wr_toggle_a, bit_cnt_a};
   assign act_b = {cmd_b, cmd_valid_b, cmd_err_b, addr_b, rd_req_b, rd_momment_b,
                   rd_toggle_b, wr_data_b, wr_toggle_b, bit_cnt_b};

   snap_t exp_a[$];
   snap_t exp_b[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    frame_no    = 0;
   logic  fb [0:MAXB-1];

   // ------------------------------------------------------------ reference model
   function automatic logic [7:0] byte_at(input int pos);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = fb[pos+i];
      return b;
   endfunction

   function automatic logic [15:0] addr_field();
      logic [15:0] a;
      for (int i = 0; i < AB; i++) a[AB-1-i] = fb[8+i];
      return a;
   endfunction

   // Outputs after edge e (1-based) of the current frame, for a decoder with
   // d dummy bits.
   function automatic snap_t model_at(input int e, input int d);
      snap_t      s;
      logic [7:0] op;
      bit         good;
      int         nb;
      s    = '0;
      op   = byte_at(0);
      good = (op == 8'h03) || (op == 8'h02);
      s.bit_cnt = 24'(e);
      if (e >= 8) begin
         s.cmd       = op;
         s.cmd_valid = 1'b1;
         s.cmd_err   = !good;
      end
      if (good && e >= 8 + AB) begin
         s.addr = addr_field();
         if (op == 8'h03) begin
            s.rd_req     = 1'b1;
            s.rd_momment = 24'(8 + AB + d);
            nb = (e >= 8 + AB + d) ? (e - 8 - AB - d) / 8 : 0;
            s.rd_toggle = nb[0];
            if (INC) s.addr = s.addr + 16'(nb);
         end else begin
            nb = (e - 8 - AB) / 8;
            s.wr_toggle = nb[0];
            if (nb > 0) begin
               s.wr_data = byte_at(8 + AB + 8 * (nb - 1));
               if (INC) s.addr = s.addr + 16'(nb - 1);
            end
         end
      end
      return s;
   endfunction

   task automatic push_expected(input int n);
      logic [7:0] op;
      int d;
      int start;
      op = byte_at(0);
      for (int k = 0; k < 2; k++) begin
         int edges[$];
         d = (k == 0) ? 8 : 0;
         if (n >= 8) edges.push_back(8);
         if (op == 8'h03 || op == 8'h02) begin
            if (op == 8'h03 && n >= 8 + AB) edges.push_back(8 + AB);
            start = (op == 8'h03) ? 8 + AB + d + 8 : 8 + AB + 8;
            for (int e = start; e <= n; e += 8) edges.push_back(e);
         end
         foreach (edges[i]) begin
            if (k == 0) exp_a.push_back(model_at(edges[i], d));
            else        exp_b.push_back(model_at(edges[i], d));
         end
      end
   endtask

   // ------------------------------------------------------------ comparison
   task automatic compare(input snap_t exp, input snap_t act, input string tag);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s frame %0d: got cmd=%h v=%b e=%b addr=%h rq=%b mom=%0d rt=%b wd=%h wt=%b bc=%0d, required cmd=%h v=%b e=%b addr=%h rq=%b mom=%0d rt=%b wd=%h wt=%b bc=%0d",
                  tag, frame_no,
                  act.cmd, act.cmd_valid, act.cmd_err, act.addr, act.rd_req, act.rd_momment,
                  act.rd_toggle, act.wr_data, act.wr_toggle, act.bit_cnt,
                  exp.cmd, exp.cmd_valid, exp.cmd_err, exp.addr, exp.rd_req, exp.rd_momment,
                  exp.rd_toggle, exp.wr_data, exp.wr_toggle, exp.bit_cnt);
      end else begin
         $display("ok   %s frame %0d edge %0d cmd=%h addr=%h rq=%b rt=%b wd=%h wt=%b",
                  tag, frame_no, act.bit_cnt, act.cmd, act.addr, act.rd_req,
                  act.rd_toggle, act.wr_data, act.wr_toggle);
      end
   endtask

   function automatic bit is_event(input snap_t cur, input snap_t prev);
      return (cur.cmd_valid && !prev.cmd_valid) || (cur.rd_req && !prev.rd_req) ||
             (cur.rd_toggle != prev.rd_toggle) || (cur.wr_toggle != prev.wr_toggle);
   endfunction

   // ------------------------------------------------------------ monitors
   snap_t prev_a = '0;
   snap_t prev_b = '0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && is_event(act_a, prev_a)) begin
         if (exp_a.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL D8 unexpected event frame %0d: got edge %0d, required none", frame_no, act_a.bit_cnt);
         end else begin
            compare(exp_a.pop_front(), act_a, "D8 event");
         end
      end
      prev_a = act_a;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && is_event(act_b, prev_b)) begin
         if (exp_b.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL D0 unexpected event frame %0d: got edge %0d, required none", frame_no, act_b.bit_cnt);
         end else begin
            compare(exp_b.pop_front(), act_b, "D0 event");
         end
      end
      prev_b = act_b;
   end

   // ------------------------------------------------------------ stimulus
   task automatic load_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
      logic [39:0] w;
      w = {b0, b1, b2, b3, b4};
      for (int i = 0; i < MAXB; i++) fb[i] = (i < 40) ? w[39-i] : 1'($urandom);
   endtask

   // Runs n sampling edges of the loaded frame, then deasserts CS (reset).
   task automatic run_frame(input int n);
      frame_no++;
      push_expected(n);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < n; i++) begin
         mosi = fb[i];
         @(posedge clk); #2;
      end
      @(negedge clk); #1;
      vectors++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         miscompares++;
         $display("FAIL missing events frame %0d: got %0d/%0d still pending, required 0/0",
                  frame_no, exp_a.size(), exp_b.size());
         exp_a.delete();
         exp_b.delete();
      end
      rst_n = 1'b0;
      mosi  = 1'b0;
      #1;
      compare('0, act_a, "D8 reset");
      compare('0, act_b, "D0 reset");
      @(negedge clk); #1;
   endtask

   initial begin
      logic [7:0]  op;
      logic [15:0] a;
      int          sel;
      int          n;
      rst_n = 1'b0;
      mosi  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      compare('0, act_a, "D8 reset");
      compare('0, act_b, "D0 reset");

      // read of 1234: two read bytes worth of edges after the dummy phase
      load_frame(8'h03, 8'h12, 8'h34, 8'($urandom), 8'($urandom));
      run_frame(48);
      // write burst A5, 5A at 0010
      load_frame(8'h02, 8'h00, 8'h10, 8'hA5, 8'h5A);
      run_frame(40);
      // unknown opcode, then 24 more bits
      load_frame(8'h9F, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_frame(32);
      // CS abort in the middle of the second write byte
      load_frame(8'h02, 8'h00, 8'h10, 8'hA5, 8'h5A);
      run_frame(36);
      // address wrap FFFF -> 0000
      load_frame(8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22);
      run_frame(40);
      // read of 0000
      load_frame(8'h03, 8'h00, 8'h00, 8'($urandom), 8'($urandom));
      run_frame(40);

      for (int f = 0; f < 40; f++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0, 3:    op = 8'h03;
            1:       op = 8'h02;
            default: op = 8'($urandom);
         endcase
         a = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
         load_frame(op, a[15:8], a[7:0], 8'($urandom), 8'($urandom));
         n = int'($urandom_range(1, 100));
         run_frame(n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
